operand_stack: RTL and testbench
================================

// Module: operand_stack
// PURPOSE
//  Parametrised LIFO operand stack for the stack-machine datapath; successor to the fixed 8x16 stack.
//  Executes one stack op per cycle; top-of-stack (tos) and next-on-stack (nos) are readable combinationally.
//  Adds DUP/SWAP/replace ops, full/empty status, and sticky overflow/underflow flags with safe rejection.
//  Sits between the decoder (drives op) and the ALU (consumes tos/nos, returns result on wr_data).
// PARAMETERS
//  WIDTH  8   data word width in bits
//  DEPTH  16  number of entries; power of 2, >= 4
// PORTS
//  clock      in   1               rising-edge clock
//  reset_n    in   1               asynchronous, active-low reset
//  op         in   3               stack_pkg::stack_op_e, sampled every cycle
//  wr_data    in   WIDTH           value pushed by PUSH, POP1_PUSH, POP2_PUSH
//  clear      in   1               synchronous flush: count->0, error flags->0; overrides op
//  tos        out  WIDTH           entry at count-1; 0 when empty
//  nos        out  WIDTH           entry at count-2; 0 when count<2
//  count      out  $clog2(DEPTH+1) number of valid entries
//  full       out  1               count==DEPTH
//  empty      out  1               count==0
//  overflow   out  1               sticky: an op was rejected for lack of space
//  underflow  out  1               sticky: an op was rejected for lack of operands
//  op_err     out  1               single-cycle combinational: current op will be rejected
// BEHAVIOUR
//  Reset (reset_n low, async): count=0, overflow=underflow=0; storage contents not reset; tos=nos=0.
//  Op table (need = operands required, net = count change):
//   NOP       need0 net 0
//   PUSH      need0 net+1  mem[count]<=wr_data
//   POP1      need1 net-1
//   POP2      need2 net-2
//   POP1_PUSH need1 net 0  mem[count-1]<=wr_data (unary result)
//   POP2_PUSH need2 net-1  mem[count-2]<=wr_data (binary result)
//   DUP       need1 net+1  mem[count]<=tos
//   SWAP      need2 net 0  mem[count-1]<=nos, mem[count-2]<=tos (same edge)
//  Underflow: count<need -> op rejected (no write, count held), underflow<=1, op_err=1.
//  Overflow: count+net>DEPTH -> op rejected, overflow<=1, op_err=1. POP1_PUSH/POP2_PUSH on full stack legal.
//  Rejection is all-or-nothing; no partial pop. Underflow check takes priority (only one flag set per op).
//  Latency: tos/nos/count/full/empty reflect an op on the clock edge after it is presented; reads are
//   combinational from storage (zero read latency), so back-to-back dependent ops need no stall.
//  Sticky flags clear only on reset_n or clear; clear wins over any op in the same cycle.
//  Arithmetic: count is unsigned, never wraps; index math done at $clog2(DEPTH) bits, only used when
//   the guard conditions above hold, so no modular aliasing reaches storage.
//  Reset mid-operation: asynchronous; any in-flight op is discarded, no write occurs that edge.
// STRUCTURE
//  stack_pkg: stack_op_e enum (NOP=0,PUSH,POP1,POP2,POP1_PUSH,POP2_PUSH,DUP,SWAP), need/net lookup function.
//  Sub-module stack_regfile #(WIDTH,DEPTH): two async read ports, two sync write ports (for SWAP),
//   port-1 write wins on address clash (never occurs by construction; assert it).
//  operand_stack: op decode, guard/reject logic, count register, sticky flag registers.
// TESTING
//  1. Reset then PUSH 0x11,0x22,0x33 -> count=3, tos=0x33, nos=0x22, empty=0, no flags.
//  2. From 1: SWAP -> tos=0x22, nos=0x33; POP2_PUSH wr_data=0x55 -> count=2, tos=0x55, nos=0x11.
//  3. DEPTH pushes then PUSH 0xAA -> op_err=1 that cycle, overflow=1, count=DEPTH, tos unchanged;
//     then POP1_PUSH 0xBB -> accepted, tos=0xBB, full=1.
//  4. Empty stack POP2 -> op_err=1, underflow=1, count=0; count=1 then SWAP -> rejected, tos unchanged.
//  5. DUP with count=1, tos=0x7E -> count=2, tos=nos=0x7E; clear with PUSH same cycle -> count=0, flags=0.
//  6. Drop reset_n mid-sequence between edges -> count=0, flags=0, tos=nos=0 immediately (async).

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack: opcode encoding and per-op
// operand requirement / count change lookups.
package stack_pkg;

    typedef enum logic [2:0] {
        NOP       = 3'd0,
        PUSH      = 3'd1,
        POP1      = 3'd2,
        POP2      = 3'd3,
        POP1_PUSH = 3'd4,
        POP2_PUSH = 3'd5,
        DUP       = 3'd6,
        SWAP      = 3'd7
    } stack_op_e;

    function automatic logic [1:0] op_need(input stack_op_e op);
        case (op)
            POP1, POP1_PUSH, DUP:  op_need = 2'd1;
            POP2, POP2_PUSH, SWAP: op_need = 2'd2;
            default:               op_need = 2'd0;
        endcase
    endfunction

    function automatic logic signed [2:0] op_net(input stack_op_e op);
        case (op)
            PUSH, DUP:       op_net = 3'sd1;
            POP1, POP2_PUSH: op_net = -3'sd1;
            POP2:            op_net = -3'sd2;
            default:         op_net = 3'sd0;
        endcase
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: two combinational read ports, two synchronous write ports.
// Write port 1 takes precedence if both target the same entry.
module stack_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic [$clog2(DEPTH)-1:0] ra_a,
    input  logic [$clog2(DEPTH)-1:0] ra_b,
    output logic [WIDTH-1:0]         rd_a,
    output logic [WIDTH-1:0]         rd_b,
    input  logic                     we0,
    input  logic [$clog2(DEPTH)-1:0] wa0,
    input  logic [WIDTH-1:0]         wd0,
    input  logic                     we1,
    input  logic [$clog2(DEPTH)-1:0] wa1,
    input  logic [WIDTH-1:0]         wd1
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_a = mem[ra_a];
    assign rd_b = mem[ra_b];

    always_ff @(posedge clock) begin
        if (we0) mem[wa0] <= wd0;
        if (we1) mem[wa1] <= wd1;
    end

    // SWAP is the only dual-write op and always targets two distinct entries.
    write_clash_a : assert property (@(posedge clock) !(we0 && we1 && (wa0 == wa1)));

endmodule

// File: rtl/operand_stack.sv
// Parametrised LIFO operand stack: op decode, guard/reject logic, count and
// sticky error flags around a dual-port register file.
module operand_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       clear,
    output logic [WIDTH-1:0]           tos,
    output logic [WIDTH-1:0]           nos,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       op_err
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    stack_op_e          op_e;
    logic [1:0]         need;
    logic signed [2:0]  net;
    logic               under_rej, over_rej, accept;
    logic [ADDR_W-1:0]  idx_new, idx_top, idx_nos;
    logic [WIDTH-1:0]   rd_a, rd_b;
    logic               we0, we1;
    logic [ADDR_W-1:0]  wa0, wa1;
    logic [WIDTH-1:0]   wd0, wd1;
    logic [CNT_W-1:0]   count_nxt;

    assign op_e = stack_op_e'(op);
    assign need = op_net_need_sel();
    assign net  = op_net(op_e);

    function automatic logic [1:0] op_net_need_sel();
        return op_need(op_e);
    endfunction

    // Index math wraps at ADDR_W bits; results are only used once the guards pass.
    assign idx_new = count[ADDR_W-1:0];
    assign idx_top = count[ADDR_W-1:0] - ADDR_W'(1);
    assign idx_nos = count[ADDR_W-1:0] - ADDR_W'(2);

    assign under_rej = (count < {{(CNT_W-2){1'b0}}, need});
    assign over_rej  = !under_rej && (net == 3'sd1) && (count == CNT_W'(DEPTH));
    assign accept    = !clear && !under_rej && !over_rej;
    assign op_err    = !clear && (under_rej || over_rej);

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign tos   = (count >= CNT_W'(1)) ? rd_a : '0;
    assign nos   = (count >= CNT_W'(2)) ? rd_b : '0;

    always_comb begin
        we0       = 1'b0;
        we1       = 1'b0;
        wa0       = idx_new;
        wa1       = idx_nos;
        wd0       = wr_data;
        wd1       = tos;
        count_nxt = count;
        if (accept) begin
            case (op_e)
                PUSH:      begin we0 = 1'b1; wa0 = idx_new; end
                POP1_PUSH: begin we0 = 1'b1; wa0 = idx_top; end
                POP2_PUSH: begin we0 = 1'b1; wa0 = idx_nos; end
                DUP:       begin we0 = 1'b1; wa0 = idx_new; wd0 = tos; end
                SWAP: begin
                    we0 = 1'b1; wa0 = idx_top; wd0 = nos;
                    we1 = 1'b1; wa1 = idx_nos; wd1 = tos;
                end
                default: ;
            endcase
            case (net)
                3'sd1:   count_nxt = count + CNT_W'(1);
                -3'sd1:  count_nxt = count - CNT_W'(1);
                -3'sd2:  count_nxt = count - CNT_W'(2);
                default: count_nxt = count;
            endcase
        end
        if (clear) count_nxt = '0;
        // An edge that lands while reset is asserted must not disturb storage.
        if (!reset_n) begin
            we0 = 1'b0;
            we1 = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count <= count_nxt;
            if (clear) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                overflow  <= overflow  | over_rej;
                underflow <= underflow | under_rej;
            end
        end
    end

    stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_regfile (
        .clock (clock),
        .ra_a  (idx_top),
        .ra_b  (idx_nos),
        .rd_a  (rd_a),
        .rd_b  (rd_b),
        .we0   (we0),
        .wa0   (wa0),
        .wd0   (wd0),
        .we1   (we1),
        .wa1   (wa1),
        .wd1   (wd1)
    );

endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack (WIDTH=8, DEPTH=16) with hand-computed
// expectations checked by immediate assertions.
module tb_operand_stack;
    import stack_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [2:0]       op;
    logic [WIDTH-1:0] wr_data;
    logic             clear;
    logic [WIDTH-1:0] tos, nos;
    logic [4:0]       count;
    logic             full, empty, overflow, underflow, op_err;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .op        (op),
        .wr_data   (wr_data),
        .clear     (clear),
        .tos       (tos),
        .nos       (nos),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow),
        .op_err    (op_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: present op, take one rising edge, return at the next negedge.
    task automatic do_op(input logic [2:0] o, input logic [WIDTH-1:0] d, input logic clr);
        op = o; wr_data = d; clear = clr;
        @(posedge clock);
        @(negedge clock);
        op = NOP; wr_data = '0; clear = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; op = NOP; wr_data = '0; clear = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_tos", tos, 0);
        chk("rst_nos", nos, 0);
        chk("rst_flags", {overflow, underflow}, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Basic pushes
        do_op(PUSH, 8'h11, 0);
        do_op(PUSH, 8'h22, 0);
        do_op(PUSH, 8'h33, 0);
        chk("t1_count", count, 3);
        chk("t1_tos", tos, 8'h33);
        chk("t1_nos", nos, 8'h22);
        chk("t1_empty", empty, 0);
        chk("t1_flags", {overflow, underflow}, 0);

        // SWAP then binary result
        do_op(SWAP, 8'h00, 0);
        chk("t2_swap_tos", tos, 8'h22);
        chk("t2_swap_nos", nos, 8'h33);
        do_op(POP2_PUSH, 8'h55, 0);
        chk("t2_count", count, 2);
        chk("t2_tos", tos, 8'h55);
        chk("t2_nos", nos, 8'h11);

        // Fill to DEPTH, then overflow
        do_op(NOP, 8'h00, 1);
        for (int i = 0; i < DEPTH; i++) do_op(PUSH, 8'(8'h10 + i), 0);
        chk("t3_full", full, 1);
        chk("t3_tos_fill", tos, 8'h1F);
        op = PUSH; wr_data = 8'hAA; #1;
        chk("t3_op_err", op_err, 1);
        @(negedge clock);
        do_op(NOP, 8'h00, 0);
        chk("t3_overflow", overflow, 1);
        chk("t3_underflow", underflow, 0);
        chk("t3_count", count, DEPTH);
        chk("t3_tos_held", tos, 8'h1F);
        op = POP1_PUSH; wr_data = 8'hBB; #1;
        chk("t3_p1p_no_err", op_err, 0);
        @(negedge clock);
        op = NOP;
        chk("t3_p1p_tos", tos, 8'hBB);
        chk("t3_p1p_nos", nos, 8'h1E);
        chk("t3_p1p_full", full, 1);

        // Underflow on empty, rejected SWAP on single entry
        do_op(NOP, 8'h00, 1);
        chk("t4_clear_count", count, 0);
        chk("t4_clear_flags", {overflow, underflow}, 0);
        op = POP2; #1;
        chk("t4_op_err", op_err, 1);
        @(negedge clock);
        op = NOP;
        chk("t4_underflow", underflow, 1);
        chk("t4_overflow", overflow, 0);
        chk("t4_count", count, 0);
        do_op(PUSH, 8'h42, 0);
        op = SWAP; #1;
        chk("t4_swap_err", op_err, 1);
        @(negedge clock);
        op = NOP;
        chk("t4_swap_tos", tos, 8'h42);
        chk("t4_swap_count", count, 1);

        // DUP, then clear overriding a PUSH
        do_op(POP1, 8'h00, 0);
        do_op(PUSH, 8'h7E, 0);
        do_op(DUP, 8'h00, 0);
        chk("t5_count", count, 2);
        chk("t5_tos", tos, 8'h7E);
        chk("t5_nos", nos, 8'h7E);
        chk("t5_sticky", underflow, 1);
        do_op(PUSH, 8'h01, 1);
        chk("t5_clr_count", count, 0);
        chk("t5_clr_flags", {overflow, underflow}, 0);
        chk("t5_clr_empty", empty, 1);

        // Asynchronous reset between edges
        do_op(PUSH, 8'h12, 0);
        do_op(PUSH, 8'h34, 0);
        do_op(POP2, 8'h00, 0);
        do_op(POP2, 8'h00, 0);
        do_op(PUSH, 8'h56, 0);
        chk("t6_pre_underflow", underflow, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_count", count, 0);
        chk("t6_tos", tos, 0);
        chk("t6_nos", nos, 0);
        chk("t6_flags", {overflow, underflow}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        do_op(NOP, 8'h00, 0);
        chk("t6_post_count", count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1);
    end

endmodule
